// File: rtl/pre_arbiter_pkg.sv
// Shared definitions for the descriptor distributor: FSM encoding, width
// helpers derived from the block parameters, and the drop-counter ceiling.
package pre_arbiter_pkg;

  typedef enum logic {
    lpIDLE     = 1'b0,
    lpDISPATCH = 1'b1
  } state_t;

  localparam logic [15:0] lpDROP_MAX = 16'hFFFF;

  // Width of a destination port index; never narrower than one bit.
  function automatic int port_idx_w(input int port_num);
    return (port_num > 1) ? $clog2(port_num) : 1;
  endfunction

  // Width of a packet RAM pointer.
  function automatic int ptr_w(input int depth_ram);
    return (depth_ram > 1) ? $clog2(depth_ram) : 1;
  endfunction

  // Width of a {length, pointer} descriptor.
  function automatic int desc_w(input int fifo_width, input int depth_ram);
    return fifo_width + ptr_w(depth_ram);
  endfunction

endpackage

// File: rtl/pre_arbiter_mask_dec.sv
// Destination decoder: turns a port index / broadcast request into the set of
// descriptor FIFOs that must receive the descriptor. An empty set means the
// descriptor is dropped (self-addressed or out-of-range index).
module pre_arbiter_mask_dec
  import pre_arbiter_pkg::*;
#(
  parameter int pPORT_NUM = 4,
  parameter int pSELF_ID  = 0,
  parameter int pBCAST_EN = 1
) (
  input  logic [port_idx_w(pPORT_NUM)-1:0] i_port_num,
  input  logic                             i_bcast,
  output logic [pPORT_NUM-1:0]             o_mask,
  output logic                             o_drop
);

  localparam logic [pPORT_NUM-1:0] ONE_HOT0 = pPORT_NUM'(1);
  localparam logic [pPORT_NUM-1:0] SELF_BIT = ONE_HOT0 << pSELF_ID;

  logic bcast;
  logic idx_legal;

  assign bcast     = i_bcast & (pBCAST_EN != 0);
  assign idx_legal = (int'(i_port_num) < pPORT_NUM) && (int'(i_port_num) != pSELF_ID);

  // Build the target set: every other port on broadcast, else the single legal port.
  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    o_mask = '0;
    if (bcast) begin
      o_mask = ~SELF_BIT;
    end else if (idx_legal) begin
      o_mask = ONE_HOT0 << i_port_num;
    end
    o_drop = (o_mask == '0);
  end

endmodule

// File: rtl/pre_arbiter_dist.sv
// Per-input-port descriptor distributor. Accepts one {length, pointer}
// descriptor per handshake and pushes it into the descriptor FIFO of each
// target output port, retrying blocked targets every cycle until all have
// taken it. Only one descriptor is in flight, which keeps per-port order.
module pre_arbiter_dist
  import pre_arbiter_pkg::*;
#(
  parameter int pPORT_NUM   = 4,
  parameter int pFIFO_WIDTH = 16,
  parameter int pDEPTH_RAM  = 1024,
  parameter int pSELF_ID    = 0,
  parameter int pBCAST_EN   = 1
) (
  input  logic                                    iclk,
  input  logic                                    i_rst_n,
  input  logic                                    i_valid,
  output logic                                    o_ready,
  input  logic [port_idx_w(pPORT_NUM)-1:0]        i_port_num,
  input  logic                                    i_bcast,
  input  logic [pFIFO_WIDTH-1:0]                  i_length,
  input  logic [ptr_w(pDEPTH_RAM)-1:0]            i_pointer,
  output logic [pPORT_NUM-1:0]                    o_push,
  output logic [desc_w(pFIFO_WIDTH,pDEPTH_RAM)-1:0] o_desc,
  input  logic [pPORT_NUM-1:0]                    i_full,
  output logic [pPORT_NUM-1:0]                    o_request,
  output logic [15:0]                             o_drop_cnt
);

  localparam int DW = desc_w(pFIFO_WIDTH, pDEPTH_RAM);

  state_t                 state_q, state_d;
  logic [pPORT_NUM-1:0]   pending_q, pending_d;
  logic [DW-1:0]          desc_q, desc_d;
  logic [15:0]            drop_q, drop_d;

  logic [pPORT_NUM-1:0]   mask;
  logic                   drop;
  logic [pPORT_NUM-1:0]   remaining;
  logic                   accept;

  pre_arbiter_mask_dec #(
    .pPORT_NUM (pPORT_NUM),
    .pSELF_ID  (pSELF_ID),
    .pBCAST_EN (pBCAST_EN)
  ) u_mask_dec (
    .i_port_num (i_port_num),
    .i_bcast    (i_bcast),
    .o_mask     (mask),
    .o_drop     (drop)
  );

  // State register: FSM state, pending targets, held descriptor, drop count.
  always_ff @(posedge iclk) begin
    // NOTE: the held descriptor is a plain register, so it is cleared on reset like the rest.
    if (!i_rst_n) begin
      state_q   <= lpIDLE;
      pending_q <= '0;
      desc_q    <= '0;
      drop_q    <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q   <= state_d;
      pending_q <= pending_d;
      desc_q    <= desc_d;
      drop_q    <= drop_d;
    end
  end

  // Handshake, push strobes and next-state: blocked targets stay pending.
  always_comb begin
    remaining = pending_q & i_full;
    o_ready   = (state_q == lpIDLE) || (remaining == '0);
    accept    = i_valid & o_ready;
    o_push    = (state_q == lpDISPATCH) ? (pending_q & ~i_full) : '0;

    state_d   = state_q;
    pending_d = remaining;
    desc_d    = desc_q;
    drop_d    = drop_q;

    if ((state_q == lpDISPATCH) && (remaining == '0)) begin
      state_d = lpIDLE;
    end

    if (accept) begin
      if (drop) begin
        if (drop_q != lpDROP_MAX) begin
          drop_d = drop_q + 16'd1;
        end
        pending_d = '0;
      end else begin
        pending_d = mask;
        desc_d    = {i_length, i_pointer};
        state_d   = lpDISPATCH;
      end
    end
  end

  assign o_desc     = desc_q;
  assign o_request  = pending_q;
  assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_pre_arbiter_dist.sv
// Self-checking bench for pre_arbiter_dist: a set-based reference model is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_pre_arbiter_dist;

  localparam int N     = 6;
  localparam int FW    = 16;
  localparam int DEPTH = 1024;
  localparam int SELF  = 0;
  localparam int PW    = $clog2(N);
  localparam int PTRW  = $clog2(DEPTH);
  localparam int DW    = FW + PTRW;

  logic            iclk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_valid = 1'b0;
  logic            i_bcast = 1'b0;
  logic [PW-1:0]   i_port_num = '0;
  logic [FW-1:0]   i_length = '0;
  logic [PTRW-1:0] i_pointer = '0;
  logic [N-1:0]    i_full = '0;
  logic            o_ready;
  logic [N-1:0]    o_push;
  logic [DW-1:0]   o_desc;
  logic [N-1:0]    o_request;
  logic [15:0]     o_drop_cnt;

  pre_arbiter_dist #(
    .pPORT_NUM   (N),
    .pFIFO_WIDTH (FW),
    .pDEPTH_RAM  (DEPTH),
    .pSELF_ID    (SELF),
    .pBCAST_EN   (1)
  ) dut (
    .iclk       (iclk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_port_num (i_port_num),
    .i_bcast    (i_bcast),
    .i_length   (i_length),
    .i_pointer  (i_pointer),
    .o_push     (o_push),
    .o_desc     (o_desc),
    .i_full     (i_full),
    .o_request  (o_request),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 iclk = ~iclk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the set of ports still owed the current descriptor.
  logic [N-1:0]  m_pend  = '0;
  logic [DW-1:0] m_desc  = '0;
  int            m_drops = 0;

  function automatic logic [N-1:0] targets(input logic bc, input int port);
    logic [N-1:0] t;
    t = '0;
    for (int p = 0; p < N; p++) begin
      if (p != SELF && (bc || p == port)) t[p] = 1'b1;
    end
    return t;
  endfunction

  always @(posedge iclk) begin
    logic [N-1:0] t;
    if (!i_rst_n) begin
      m_pend  = '0;
      m_desc  = '0;
      m_drops = 0;
    end else if (i_valid && ((m_pend & i_full) == '0)) begin
      t = targets(i_bcast, int'(i_port_num));
      if (t == '0) begin
        if (m_drops < 65535) m_drops++;
        m_pend = '0;
      end else begin
        m_pend = t;
        m_desc = {i_length, i_pointer};
      end
    end else begin
      m_pend = m_pend & i_full;
    end
  end

  // Per-cycle comparison against the model, away from the clock edge.
  always @(negedge iclk) begin
    #2;
    if (chk_en) begin
      check("push",    o_push,     m_pend & ~i_full);
      check("ready",   o_ready,    (m_pend & i_full) == '0);
      check("request", o_request,  m_pend);
      check("drops",   o_drop_cnt, m_drops);
      if (m_pend != '0) check("desc", o_desc, m_desc);
    end
  end

  // Drive one cycle of inputs at the falling edge, then settle past the compare.
  task automatic cyc(input logic v, input logic b, input int port,
                     input logic [FW-1:0] len, input logic [PTRW-1:0] ptr,
                     input logic [N-1:0] full);
    @(negedge iclk);
    i_valid    = v;
    i_bcast    = b;
    i_port_num = PW'(port);
    i_length   = len;
    i_pointer  = ptr;
    i_full     = full;
    #3;
  endtask

  initial begin
    // Reset
    cyc(0, 0, 0, '0, '0, '0);
    cyc(0, 0, 0, '0, '0, '0);
    chk_en = 1'b1;
    @(negedge iclk);
    i_rst_n = 1'b1;
    #3;
    check("rst_ready",   o_ready,    1'b1);
    check("rst_push",    o_push,     '0);
    check("rst_request", o_request,  '0);
    check("rst_desc",    o_desc,     '0);
    check("rst_drops",   o_drop_cnt, 16'd0);

    // Single unicast to port 2
    cyc(1, 0, 2, 16'h0040, 10'h010, '0);
    cyc(0, 0, 0, '0, '0, '0);
    check("uni_push",    o_push,    6'b000100);
    check("uni_desc",    o_desc,    {16'h0040, 10'h010});
    check("uni_request", o_request, 6'b000100);
    cyc(0, 0, 0, '0, '0, '0);
    check("uni_idle_req", o_request, '0);
    check("uni_idle_push", o_push,   '0);

    // Broadcast with port 2 full for three cycles
    cyc(1, 1, 0, 16'h1234, 10'h2AB, '0);
    cyc(0, 0, 0, '0, '0, 6'b000100);
    check("bc_push1",  o_push,    6'b111010);
    check("bc_ready1", o_ready,   1'b0);
    check("bc_req1",   o_request, 6'b111110);
    cyc(0, 0, 0, '0, '0, 6'b000100);
    check("bc_req2",   o_request, 6'b000100);
    check("bc_push2",  o_push,    '0);
    cyc(0, 0, 0, '0, '0, 6'b000100);
    check("bc_req3",   o_request, 6'b000100);
    check("bc_desc3",  o_desc,    {16'h1234, 10'h2AB});
    cyc(0, 0, 0, '0, '0, '0);
    check("bc_push4",  o_push,    6'b000100);
    check("bc_ready4", o_ready,   1'b1);

    // Self drop, illegal index drop, then legal top port
    cyc(1, 0, 0, 16'h0001, 10'h001, '0);
    check("self_ready", o_ready, 1'b1);
    cyc(1, 0, 6, 16'h0002, 10'h002, '0);
    check("self_drops", o_drop_cnt, 16'd1);
    check("self_push",  o_push,     '0);
    check("ill_ready",  o_ready,    1'b1);
    cyc(1, 0, 5, 16'h0003, 10'h003, '0);
    check("ill_drops",  o_drop_cnt, 16'd2);
    cyc(0, 0, 0, '0, '0, '0);
    check("p5_push",    o_push,     6'b100000);
    check("p5_desc",    o_desc,     {16'h0003, 10'h003});

    // Back-to-back to ports 1, 2, 3
    cyc(1, 0, 1, 16'h0011, 10'h011, '0);
    cyc(1, 0, 2, 16'h0022, 10'h022, '0);
    check("b2b_push1", o_push, 6'b000010);
    check("b2b_rdy1",  o_ready, 1'b1);
    cyc(1, 0, 3, 16'h0033, 10'h033, '0);
    check("b2b_push2", o_push, 6'b000100);
    check("b2b_rdy2",  o_ready, 1'b1);
    cyc(0, 0, 0, '0, '0, '0);
    check("b2b_push3", o_push, 6'b001000);
    check("b2b_desc3", o_desc, {16'h0033, 10'h033});
    cyc(0, 0, 0, '0, '0, '0);
    check("b2b_done",  o_push, '0);

    // Randomised traffic with random backpressure
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] f;
      for (int p = 0; p < N; p++) f[p] = ($urandom_range(3) == 0);
      cyc($urandom_range(3) != 0, $urandom_range(4) == 0, $urandom_range(7),
          FW'($urandom), PTRW'($urandom), f);
    end
    cyc(0, 0, 0, '0, '0, '0);
    cyc(0, 0, 0, '0, '0, '0);

    // Reset while port 3 is blocked mid-dispatch
    cyc(1, 0, 3, 16'h0BAD, 10'h0BD, '0);
    cyc(0, 0, 0, '0, '0, 6'b001000);
    check("rd_push",  o_push,  '0);
    check("rd_ready", o_ready, 1'b0);
    @(negedge iclk);
    i_rst_n = 1'b0;
    @(negedge iclk);
    i_rst_n = 1'b1;
    i_full  = '0;
    #3;
    check("rd_after_push",  o_push,    '0);
    check("rd_after_req",   o_request, '0);
    check("rd_after_ready", o_ready,   1'b1);
    cyc(0, 0, 0, '0, '0, '0);
    check("rd_no_push", o_push, '0);

    // Drop-counter saturation
    for (int i = 0; i < 65537; i++) cyc(1, 0, SELF, '0, '0, '0);
    cyc(0, 0, 0, '0, '0, '0);
    check("sat_drops", o_drop_cnt, 16'hFFFF);
    check("sat_ready", o_ready,    1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
